nios_security_gps_pio_in: RTL and testbench
===========================================

// Module: nios_security_gps_pio_in
// PURPOSE
//  Parametrised Avalon-MM input PIO for GPS/sensor status lines on the Nios security subsystem.
//  - Synchronises WIDTH async inputs and captures edges per bit into a W1C register.
//  - Raises a maskable irq on captured edges.
//  - Counts input changes and flags a "stale" condition when no input has changed for STALE_CYCLES clocks.
// PARAMETERS
//  WIDTH         16          input bus width, 1..32
//  EDGE_TYPE     0           capture edge: 0=rising, 1=falling, 2=any
//  SYNC_STAGES   2           synchroniser depth, 2..4
//  STALE_CYCLES  50_000_000  clocks with no input change before stale sets; >=2
// PORTS
//  clk        in   1      system clock; all logic on rising edge
//  reset      in   1      asynchronous, active-high reset
//  address    in   3      Avalon word address
//  write      in   1      Avalon write strobe, single-cycle
//  writedata  in   32     Avalon write data
//  readdata   out  32     registered read data
//  in_port    in   WIDTH  asynchronous input lines
//  irq        out  1      level interrupt, registered
// BEHAVIOUR
//  Reset: every register is 0. This covers readdata, irq, edgecap, irqmask, ctrl, change count,
//   idle counter, stale and the sync chain.
//  Sync path:
//   - in_port passes through SYNC_STAGES flops to give data_s.
//   - prev_s is data_s delayed one clock.
//   - edge = rise (data_s & ~prev_s), fall (~data_s & prev_s) or any (data_s ^ prev_s), per EDGE_TYPE.
//  Register map (readdata = zero-extended, registered every clock from the current address; valid 1 clk after address):
//   0 DATA     RO  data_s
//   1 CTRL     RW  bit0 stale (RO, 1=stale); bit1 stale_irq_en (RW); other bits read 0
//   2 IRQMASK  RW  [WIDTH-1:0]
//   3 EDGECAP  W1C [WIDTH-1:0]: bit set on edge; writing 1 clears that bit
//   4 CHGCNT   RO/W  32-bit count of clocks where data_s != prev_s; wraps 0xFFFF_FFFF->0; any write clears to 0
//   5..7       reads 0; writes ignored
//  Edge capture:
//   - edgecap <= (edgecap & ~(wr3 ? writedata : 0)) | edge.
//   - A set and a clear in the same clock: set wins.
//  Stale detector:
//   - Idle counter clears to 0 on any change (data_s != prev_s); otherwise increments.
//   - It saturates at STALE_CYCLES-1.
//   - stale sets the clock after the counter reaches STALE_CYCLES-1.
//   - stale clears the same clock a change is seen.
//   - Change and stale are never both set: change wins.
//  CHGCNT:
//   - A write and a change in the same clock give result 0 (write wins).
//  irq <= |(edgecap & irqmask) | (stale & stale_irq_en), registered 1 clk after its sources.
//  Latency:
//   - in_port transition -> data_s: SYNC_STAGES clks.
//   - -> edgecap/CHGCNT: +1 clk.
//   - -> irq: +1 clk.
//  Reset asserted mid-operation returns all state to reset values immediately. No writes are
//   accepted while reset is high.
//  Unused high bits of writedata are ignored. WIDTH=32 uses the full word.
// STRUCTURE
//  Package nios_security_pio_pkg:
//   - register offset localparams (ADDR_DATA..ADDR_CHGCNT)
//   - EDGE_RISE/EDGE_FALL/EDGE_ANY constants
//   - CTRL bit indices
//  Sub-module nios_security_pio_sync_edge (WIDTH, SYNC_STAGES, EDGE_TYPE):
//   - contains the sync chain, prev_s and edge/change outputs
//  The top holds the register file, stale detector and read mux.
// TESTING
//  1 Reset: reset high, in_port=16'hFFFF -> readdata, irq and all registers read 0 after release.
//  2 Rising capture: irqmask=16'h0005, in_port 0->16'h0001 -> EDGECAP=0x1 and irq=1 at 4 clks;
//    write EDGECAP 0x1 -> irq=0.
//  3 Set/clear collision: rising edge on bit 2 in the same clk as a W1C 0x4 -> EDGECAP bit2 stays 1.
//  4 Stale: STALE_CYCLES=8, ctrl=0x2, input held -> CTRL reads 0x3 and irq=1;
//    toggle bit0 -> stale=0 SYNC_STAGES+1 clks later.
//  5 CHGCNT: 5 input changes spaced 4 clks -> reads 5; write 0 -> reads 0;
//    preload to 0xFFFF_FFFF (force) plus 1 change -> 0.
//  6 EDGE_TYPE=1 and 2 builds: 16'h00F0->16'h000F -> falling EDGECAP=0x00F0; any EDGECAP=0x00FF.

Source files
------------

// File: rtl/nios_security_pio_pkg.sv
// ============================================================================
// Module : nios_security_pio_pkg
// Brief  : Register offsets, edge-type codes and CTRL bit indices for the PIO.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package nios_security_pio_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_CTRL    = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_CHGCNT  = 3'd4;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int CTRL_STALE_BIT        = 0;
    localparam int CTRL_STALE_IRQ_EN_BIT = 1;

    // Bits needed for a counter that must reach max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/nios_security_pio_sync_edge.sv
// ============================================================================
// Module : nios_security_pio_sync_edge
// Brief  : Multi-flop input synchroniser with one-clock-delayed copy and
//          per-bit edge / any-change detection.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module nios_security_pio_sync_edge
    import nios_security_pio_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_data_s,
    output logic [WIDTH-1:0] o_edge,
    output logic             o_change
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  r_prev;
    logic [WIDTH-1:0]                  w_data_s;

    assign w_data_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= w_data_s;
        end
    end

    generate
        if (EDGE_TYPE == EDGE_FALL) begin : g_fall
            assign o_edge = ~w_data_s & r_prev;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
            assign o_edge = w_data_s ^ r_prev;
        end else begin : g_rise
            assign o_edge = w_data_s & ~r_prev;
        end
    endgenerate

    assign o_data_s = w_data_s;
    assign o_change = |(w_data_s ^ r_prev);

endmodule

`default_nettype wire

// File: rtl/nios_security_gps_pio_in.sv
// ============================================================================
// Module : nios_security_gps_pio_in
// Brief  : Avalon-MM input PIO with W1C edge capture, maskable irq, change
//          counter and idle ("stale") detector.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module nios_security_gps_pio_in
    import nios_security_pio_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int EDGE_TYPE    = 0,
    parameter int SYNC_STAGES  = 2,
    parameter int STALE_CYCLES = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int               IDLE_W   = cnt_width(STALE_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(STALE_CYCLES - 1);

    logic [WIDTH-1:0]  w_data_s;
    logic [WIDTH-1:0]  w_edge;
    logic              w_change;
    logic [WIDTH-1:0]  w_wdata;
    logic              w_wr_ctrl;
    logic              w_wr_irqmask;
    logic              w_wr_edgecap;
    logic              w_wr_chgcnt;
    logic [31:0]       w_rdata;
    logic              w_unused;

    logic [WIDTH-1:0]  r_edgecap;
    logic [WIDTH-1:0]  r_irqmask;
    logic              r_stale_irq_en;
    logic              r_stale;
    logic [IDLE_W-1:0] r_idle;
    logic [31:0]       r_chgcnt;
    logic [31:0]       r_readdata;
    logic              r_irq;

    nios_security_pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk      (clk),
        .rst      (reset),
        .i_async  (in_port),
        .o_data_s (w_data_s),
        .o_edge   (w_edge),
        .o_change (w_change)
    );

    assign w_wdata      = writedata[WIDTH-1:0];
    assign w_unused     = ^writedata;
    assign w_wr_ctrl    = write && (address == ADDR_CTRL);
    assign w_wr_irqmask = write && (address == ADDR_IRQMASK);
    assign w_wr_edgecap = write && (address == ADDR_EDGECAP);
    assign w_wr_chgcnt  = write && (address == ADDR_CHGCNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irqmask      <= '0;
            r_stale_irq_en <= 1'b0;
        end else begin
            if (w_wr_irqmask) begin
                r_irqmask <= w_wdata;
            end
            if (w_wr_ctrl) begin
                r_stale_irq_en <= writedata[CTRL_STALE_IRQ_EN_BIT];
            end
        end
    end

    // A new edge overrides a simultaneous W1C of the same bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edgecap <= '0;
        end else begin
            r_edgecap <= (r_edgecap & ~(w_wr_edgecap ? w_wdata : '0)) | w_edge;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_chgcnt <= '0;
        end else if (w_wr_chgcnt) begin
            r_chgcnt <= '0;
        end else if (w_change) begin
            r_chgcnt <= r_chgcnt + 32'd1;
        end
    end

    // stale follows the saturated idle counter by one clock; a change clears both.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idle  <= '0;
            r_stale <= 1'b0;
        end else if (w_change) begin
            r_idle  <= '0;
            r_stale <= 1'b0;
        end else begin
            if (r_idle != IDLE_MAX) begin
                r_idle <= r_idle + IDLE_W'(1);
            end
            if (r_idle == IDLE_MAX) begin
                r_stale <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            ADDR_DATA:    w_rdata[WIDTH-1:0] = w_data_s;
            ADDR_CTRL: begin
                w_rdata[CTRL_STALE_BIT]        = r_stale;
                w_rdata[CTRL_STALE_IRQ_EN_BIT] = r_stale_irq_en;
            end
            ADDR_IRQMASK: w_rdata[WIDTH-1:0] = r_irqmask;
            ADDR_EDGECAP: w_rdata[WIDTH-1:0] = r_edgecap;
            ADDR_CHGCNT:  w_rdata            = r_chgcnt;
            default:      w_rdata            = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_readdata <= w_rdata;
            r_irq      <= (|(r_edgecap & r_irqmask)) | (r_stale & r_stale_irq_en);
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_nios_security_gps_pio_in.sv
// ============================================================================
// Module : tb_nios_security_gps_pio_in
// Brief  : Directed scoreboard bench; rising, falling and any-edge builds
//          share one Avalon bus and input bus.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_nios_security_gps_pio_in;

    localparam logic [2:0] A_DATA = 3'd0, A_CTRL = 3'd1, A_MASK = 3'd2,
                           A_ECAP = 3'd3, A_CCNT = 3'd4, A_RSVD = 3'd5;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic [15:0] in_port;
    logic [31:0] rd_rise, rd_fall, rd_any;
    logic        irq_rise, irq_fall, irq_any;

    int n_vec  = 0;
    int n_fail = 0;
    logic [31:0] q_exp[$];
    string       q_tag[$];

    always #5 clk = ~clk;

    nios_security_gps_pio_in #(.WIDTH(16), .EDGE_TYPE(0), .SYNC_STAGES(2), .STALE_CYCLES(8)) dut_rise (
        .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
        .readdata(rd_rise), .in_port(in_port), .irq(irq_rise));
    nios_security_gps_pio_in #(.WIDTH(16), .EDGE_TYPE(1), .SYNC_STAGES(2), .STALE_CYCLES(8)) dut_fall (
        .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
        .readdata(rd_fall), .in_port(in_port), .irq(irq_fall));
    nios_security_gps_pio_in #(.WIDTH(16), .EDGE_TYPE(2), .SYNC_STAGES(2), .STALE_CYCLES(8)) dut_any (
        .clk(clk), .reset(reset), .address(address), .write(write), .writedata(writedata),
        .readdata(rd_any), .in_port(in_port), .irq(irq_any));

    task automatic sb_push(input logic [31:0] e, input string t);
        q_exp.push_back(e);
        q_tag.push_back(t);
    endtask

    task automatic sb_check(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        n_vec++;
        if (q_exp.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow: observed 0x%08h required an expectation", obs);
            return;
        end
        e = q_exp.pop_front();
        t = q_tag.pop_front();
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", t, obs, e);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clk);
        write     = 1'b0;
        writedata = '0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string t);
        sb_push(e, t);
        address = a;
        @(posedge clk); #1;
        sb_check(rd_rise);
        @(negedge clk);
    endtask

    task automatic chk_irq(input logic e, input string t);
        sb_push(32'(e), t);
        sb_check(32'(irq_rise));
    endtask

    initial begin
        reset     = 1'b1;
        address   = A_DATA;
        write     = 1'b0;
        writedata = '0;
        in_port   = 16'hFFFF;
        repeat (3) @(negedge clk);

        // Reset holds everything at zero even with inputs high.
        sb_push(32'h0, "rst_readdata");
        sb_check(rd_rise);
        chk_irq(1'b0, "rst_irq");
        in_port = 16'h0000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rd(A_CTRL, 32'h0, "rst_ctrl");
        rd(A_MASK, 32'h0, "rst_irqmask");
        rd(A_ECAP, 32'h0, "rst_edgecap");
        rd(A_CCNT, 32'h0, "rst_chgcnt");
        rd(A_DATA, 32'h0, "rst_data");
        rd(A_RSVD, 32'h0, "rst_rsvd");
        chk_irq(1'b0, "rst_irq_after");

        // Rising capture and irq latency.
        wr(A_MASK, 32'hFFFF_0005);
        rd(A_MASK, 32'h0000_0005, "irqmask_rb");
        in_port = 16'h0001;
        repeat (3) @(posedge clk); #1;
        chk_irq(1'b0, "irq_before_4clk");
        @(posedge clk); #1;
        chk_irq(1'b1, "irq_at_4clk");
        @(negedge clk);
        rd(A_ECAP, 32'h1, "edgecap_rise");
        rd(A_DATA, 32'h1, "data_s");
        wr(A_ECAP, 32'h1);
        @(posedge clk); #1;
        chk_irq(1'b0, "irq_after_w1c");
        @(negedge clk);
        rd(A_ECAP, 32'h0, "edgecap_cleared");

        // W1C in the same clock as a new edge: set wins.
        in_port = 16'h0005;
        @(negedge clk);
        @(negedge clk);
        wr(A_ECAP, 32'h4);
        rd(A_ECAP, 32'h4, "collision_edgecap");
        chk_irq(1'b1, "collision_irq");
        wr(A_ECAP, 32'hFFFF);
        rd(A_ECAP, 32'h0, "edgecap_clear_all");

        // Stale detector with its irq enabled.
        wr(A_CTRL, 32'h2);
        repeat (12) @(negedge clk);
        rd(A_CTRL, 32'h3, "ctrl_stale");
        chk_irq(1'b1, "stale_irq");
        in_port = 16'h0004;
        address = A_CTRL;
        repeat (3) @(posedge clk); #1;
        sb_push(32'h3, "stale_held_p3");
        sb_check(rd_rise);
        chk_irq(1'b1, "stale_irq_p3");
        @(posedge clk); #1;
        sb_push(32'h2, "stale_cleared");
        sb_check(rd_rise);
        chk_irq(1'b0, "stale_irq_cleared");
        @(negedge clk);
        wr(A_CTRL, 32'h0);

        // Change counter.
        rd(A_CCNT, 32'd3, "chgcnt_3");
        wr(A_CCNT, 32'h0);
        rd(A_CCNT, 32'd0, "chgcnt_wclr");
        for (int i = 0; i < 5; i++) begin
            in_port = in_port ^ 16'h8000;
            repeat (4) @(negedge clk);
        end
        rd(A_CCNT, 32'd5, "chgcnt_5");
        wr(A_CCNT, 32'h0);
        rd(A_CCNT, 32'd0, "chgcnt_zero");
        in_port = in_port ^ 16'h8000;
        @(negedge clk);
        @(negedge clk);
        wr(A_CCNT, 32'h0);
        rd(A_CCNT, 32'd0, "chgcnt_write_wins");
        force dut_rise.r_chgcnt = 32'hFFFF_FFFF;
        #1;
        release dut_rise.r_chgcnt;
        rd(A_CCNT, 32'hFFFF_FFFF, "chgcnt_preload");
        in_port = in_port ^ 16'h8000;
        repeat (4) @(negedge clk);
        rd(A_CCNT, 32'h0, "chgcnt_wrap");

        // Falling / any-edge builds.
        in_port = 16'h00F0;
        repeat (6) @(negedge clk);
        wr(A_ECAP, 32'hFFFF);
        in_port = 16'h000F;
        repeat (6) @(negedge clk);
        sb_push(32'h0000_000F, "rise_edgecap");
        sb_push(32'h0000_00F0, "fall_edgecap");
        sb_push(32'h0000_00FF, "any_edgecap");
        address = A_ECAP;
        @(posedge clk); #1;
        sb_check(rd_rise);
        sb_check(rd_fall);
        sb_check(rd_any);
        sb_push(32'h0, "fall_irq");
        sb_push(32'h1, "any_irq");
        sb_check(32'(irq_fall));
        sb_check(32'(irq_any));
        @(negedge clk);

        // Mid-run reset clears outputs without waiting for a clock.
        reset = 1'b1;
        #1;
        sb_push(32'h0, "async_rst_readdata");
        sb_check(rd_any);
        sb_push(32'h0, "async_rst_irq");
        sb_check(32'(irq_any));
        @(negedge clk);
        in_port = 16'h0000;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rd(A_ECAP, 32'h0, "edgecap_after_rst");

        if (q_exp.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: observed %0d pending required 0", q_exp.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
